cnnip_fifo_lvl: RTL and testbench
=================================

Name: cnnip_fifo_lvl

Overview:
- Single-clock parametrised FIFO with a valid/ready handshake on both sides, an occupancy counter, and registered almost-full/almost-empty flags.
- Adds a synchronous flush and a high-water-mark monitor.
- Supports any DEPTH >= 1, including depth-1 and non-power-of-two depths.
- Placed between CNN datapath stages (line buffers, PE-array feeders, DMA staging), where upstream throttling uses the almost-flags.

Parameters:
- WIDTH, 32: data width in bits, >= 1.
- DEPTH, 4: number of entries, >= 1, any integer.
- AFULL_TH, DEPTH-1: afull_a asserted when level >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1: aempty_a asserted when level <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk_a, input, 1: clock.
- arstz_aq, input, 1: asynchronous active-low reset.
- clr_a, input, 1: synchronous flush; has priority over push and pop.
- in_valid_a, input, 1: upstream data valid.
- in_ready_a, output, 1: FIFO can accept data (not full).
- in_data_a, input, WIDTH: write data.
- out_valid_a, output, 1: FIFO holds data (not empty).
- out_ready_a, input, 1: downstream accepts data.
- out_data_a, output, WIDTH: head entry.
- level_a, output, CW: occupancy 0..DEPTH, where CW = $clog2(DEPTH+1).
- afull_a, output, 1: level >= AFULL_TH.
- aempty_a, output, 1: level <= AEMPTY_TH.
- hwm_a, output, CW: maximum level reached since the last reset or clear.

Behaviour:
- Reset and handshake timing:
  - Clock is clk_a. Reset arstz_aq is asynchronous, active-low. All control state clears on reset.
  - Reset values: in_ready_a=1, out_valid_a=0, level_a=0, afull_a=0, aempty_a=1, hwm_a=0. Pointers are 0. Memory is not reset.
  - push = in_valid_a & in_ready_a. pop = out_valid_a & out_ready_a.
  - in_ready_a and out_valid_a are registered and derived from level_next. There is no combinational path from in_valid_a to out_valid_a, or from out_ready_a to in_ready_a.
- Latency:
  - A push into an empty FIFO gives out_valid_a=1 on the next cycle.
  - Write-to-read latency is 1 cycle. There is no bypass.
  - out_data_a = mem[rd_ptr], a combinational read of the registered pointer. It is undefined while out_valid_a=0.
- Pointers:
  - wr_ptr and rd_ptr are PW = max(1, $clog2(DEPTH)) bits wide.
  - Each increments by 1 on push or pop and wraps from DEPTH-1 to 0. Non-power-of-two depths therefore never address an entry >= DEPTH.
  - When DEPTH=1, the pointers stay at 0.
- Level update (level_next):
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: unchanged.
- Full and empty:
  - in_ready_a = (level != DEPTH). out_valid_a = (level != 0).
  - When full, in_ready_a=0, so push cannot occur even if a pop happens in the same cycle. Space becomes visible the following cycle.
  - When empty, pop cannot occur. A same-cycle push only increments level.
- Flags:
  - afull_a and aempty_a are registered from level_next.
  - hwm_a_next = max(hwm_a, level_next).
- Flush (clr_a=1):
  - Next cycle: pointers=0, level=0, hwm=0, in_ready=1, out_valid=0, afull=0, aempty=1.
  - Any push or pop presented in the same cycle is discarded. No memory write occurs.
- Reset mid-operation: all control returns to reset values immediately (asynchronously). Stale memory contents are never exposed because out_valid_a=0.
- Invariants: level_a never exceeds DEPTH and never underflows.
- Elaboration checks: an illegal AFULL_TH, AEMPTY_TH, or DEPTH is a fatal elaboration error.

Decomposition:
- Shared package cnnip_pkg:
  - function ptr_w(depth) returning max(1, $clog2(depth)).
  - function cnt_w(depth) returning $clog2(depth+1).
- Sub-module cnnip_wrap_ctr:
  - Parameters N (modulus) and W.
  - Ports clk_a, arstz_aq, clr_a, inc_a, cnt_aq. Synchronous clear, wrap at N-1.
  - Instantiated twice, for wr_ptr and rd_ptr.
- Level, flag, HWM, and memory logic stay in the top module.

Test Plan (WIDTH=8, DEPTH=5, AFULL_TH=4, AEMPTY_TH=1 unless noted):
1. Reset, then push 0x11..0x15 on 5 cycles with out_ready=0 -> level 1,2,3,4,5. afull_a rises when level=4. in_ready_a=0 after the 5th push. hwm_a=5. A 6th in_valid is not accepted.
2. From full, pop with out_ready=1 for 5 cycles -> out_data 0x11,0x12,0x13,0x14,0x15 in order. aempty_a rises when level=1. out_valid_a=0 after the last pop.
3. Wrap test: stream 12 words with in_valid=1 and out_ready=1 continuously -> all 12 delivered in order across two pointer wraps. level_a settles at 1 with zero loss.
4. Simultaneous push and pop at level=5 -> push rejected, pop accepted, level=4. Simultaneous push and pop at level=2 -> level stays 2 and both pointers advance.
5. Push 3 words, then assert clr_a with in_valid=1 and out_ready=1 in the same cycle -> next cycle level=0, hwm=0, out_valid=0, in_ready=1, and the discarded word never appears.
6. DEPTH=1: push 0xA5, then push and pop together while full -> in_ready=0 until the pop is seen. 0xA5 is delivered. A subsequent push 0x5A is delivered correctly.

Source files
------------

// File: rtl/cnnip_pkg.sv
// Shared width helpers for the cnnip FIFO family.
package cnnip_pkg;

    // Pointer width: enough bits to address DEPTH entries, never zero.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Counter width: enough bits to represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cnnip_wrap_ctr.sv
// Modulo-N counter with synchronous clear; used for the FIFO read/write pointers.
module cnnip_wrap_ctr
    import cnnip_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk_a,
    input  logic         arstz_aq,
    input  logic         clr_a,
    input  logic         inc_a,
    output logic [W-1:0] cnt_aq
);

    localparam logic [W-1:0] Last = W'(N - 1);

    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step and wrap from N-1 back to 0.
    always_comb begin
        cnt_d = cnt_aq;
        if (clr_a) begin
            cnt_d = '0;
        end else if (inc_a) begin
            cnt_d = (cnt_aq == Last) ? '0 : cnt_aq + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            cnt_aq <= '0;
        end else begin
            cnt_aq <= cnt_d;
        end
    end

endmodule

// File: rtl/cnnip_fifo_lvl.sv
// Single-clock valid/ready FIFO with occupancy, registered almost-flags,
// synchronous flush and a high-water-mark monitor.
module cnnip_fifo_lvl
    import cnnip_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_TH  = DEPTH - 1,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                        clk_a,
    input  logic                        arstz_aq,
    input  logic                        clr_a,
    input  logic                        in_valid_a,
    output logic                        in_ready_a,
    input  logic [WIDTH-1:0]            in_data_a,
    output logic                        out_valid_a,
    input  logic                        out_ready_a,
    output logic [WIDTH-1:0]            out_data_a,
    output logic [cnt_w(DEPTH)-1:0]     level_a,
    output logic                        afull_a,
    output logic                        aempty_a,
    output logic [cnt_w(DEPTH)-1:0]     hwm_a
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
    localparam logic [CW-1:0] AFullTh  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEmptyTh = CW'(AEMPTY_TH);

    if (DEPTH == 0) begin : g_bad_depth
        $fatal(1, "cnnip_fifo_lvl: DEPTH must be >= 1");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $fatal(1, "cnnip_fifo_lvl: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH >= DEPTH) begin : g_bad_aempty
        $fatal(1, "cnnip_fifo_lvl: AEMPTY_TH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    level_q, level_d;
    logic [CW-1:0]    hwm_q, hwm_d;
    logic             in_ready_q, out_valid_q;
    logic             afull_q, aempty_q;
    logic             push, pop;

    // A flush discards any handshake presented in the same cycle.
    assign push = in_valid_a & in_ready_q & ~clr_a;
    assign pop  = out_valid_q & out_ready_a & ~clr_a;

    cnnip_wrap_ctr #(
        .N (DEPTH),
        .W (PW)
    ) u_wr_ptr (
        .clk_a    (clk_a),
        .arstz_aq (arstz_aq),
        .clr_a    (clr_a),
        .inc_a    (push),
        .cnt_aq   (wr_ptr)
    );

    cnnip_wrap_ctr #(
        .N (DEPTH),
        .W (PW)
    ) u_rd_ptr (
        .clk_a    (clk_a),
        .arstz_aq (arstz_aq),
        .clr_a    (clr_a),
        .inc_a    (pop),
        .cnt_aq   (rd_ptr)
    );

    // Next occupancy and high-water mark.
    always_comb begin
        level_d = level_q;
        if (clr_a) begin
            level_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   level_d = level_q + CW'(1);
                2'b01:   level_d = level_q - CW'(1);
                default: level_d = level_q;
            endcase
        end
        hwm_d = clr_a ? '0 : ((level_d > hwm_q) ? level_d : hwm_q);
    end

    // Control state; all handshake and flag outputs come from level_d.
    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            level_q     <= '0;
            hwm_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
        end else begin
            level_q     <= level_d;
            hwm_q       <= hwm_d;
            in_ready_q  <= (level_d != DepthC);
            out_valid_q <= (level_d != '0);
            afull_q     <= (level_d >= AFullTh);
            aempty_q    <= (level_d <= AEmptyTh);
        end
    end

    // Storage is not reset; out_valid_a gates any stale contents.
    always_ff @(posedge clk_a) begin
        if (push) begin
            mem_q[wr_ptr] <= in_data_a;
        end
    end

    assign out_data_a  = mem_q[rd_ptr];
    assign in_ready_a  = in_ready_q;
    assign out_valid_a = out_valid_q;
    assign level_a     = level_q;
    assign hwm_a       = hwm_q;
    assign afull_a     = afull_q;
    assign aempty_a    = aempty_q;

endmodule

// File: tb/tb_cnnip_fifo_lvl.sv
// Bench for cnnip_fifo_lvl: directed vector table, stream/wrap sequence,
// queue-model random traffic on a DEPTH=5 instance, and a DEPTH=1 sequence.
module tb_cnnip_fifo_lvl;

    logic clk = 1'b0;
    logic arstz;
    always #5 clk = ~clk;

    // DEPTH=5 instance signals
    logic       clr5, iv5, ordy5, ir5, ov5, af5, ae5;
    logic [7:0] din5, dout5;
    logic [2:0] lvl5, hwm5;

    // DEPTH=1 instance signals
    logic       clr1, iv1, ordy1, ir1, ov1, af1, ae1;
    logic [7:0] din1, dout1;
    logic [0:0] lvl1, hwm1;

    cnnip_fifo_lvl #(
        .WIDTH     (8),
        .DEPTH     (5),
        .AFULL_TH  (4),
        .AEMPTY_TH (1)
    ) u_dut5 (
        .clk_a       (clk),
        .arstz_aq    (arstz),
        .clr_a       (clr5),
        .in_valid_a  (iv5),
        .in_ready_a  (ir5),
        .in_data_a   (din5),
        .out_valid_a (ov5),
        .out_ready_a (ordy5),
        .out_data_a  (dout5),
        .level_a     (lvl5),
        .afull_a     (af5),
        .aempty_a    (ae5),
        .hwm_a       (hwm5)
    );

    cnnip_fifo_lvl #(
        .WIDTH     (8),
        .DEPTH     (1),
        .AFULL_TH  (1),
        .AEMPTY_TH (0)
    ) u_dut1 (
        .clk_a       (clk),
        .arstz_aq    (arstz),
        .clr_a       (clr1),
        .in_valid_a  (iv1),
        .in_ready_a  (ir1),
        .in_data_a   (din1),
        .out_valid_a (ov1),
        .out_ready_a (ordy1),
        .out_data_a  (dout1),
        .level_a     (lvl1),
        .afull_a     (af1),
        .aempty_a    (ae1),
        .hwm_a       (hwm1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk5(input string tag, input int lvl, input bit ir, input bit ov,
                        input bit af, input bit ae, input int hwm);
        chk({tag, " level"}, 32'(lvl5), lvl);
        chk({tag, " in_ready"}, 32'(ir5), 32'(ir));
        chk({tag, " out_valid"}, 32'(ov5), 32'(ov));
        chk({tag, " afull"}, 32'(af5), 32'(af));
        chk({tag, " aempty"}, 32'(ae5), 32'(ae));
        chk({tag, " hwm"}, 32'(hwm5), hwm);
    endtask

    task automatic chk1(input string tag, input int lvl, input bit ir, input bit ov,
                        input bit af, input bit ae, input int hwm);
        chk({tag, " level"}, 32'(lvl1), lvl);
        chk({tag, " in_ready"}, 32'(ir1), 32'(ir));
        chk({tag, " out_valid"}, 32'(ov1), 32'(ov));
        chk({tag, " afull"}, 32'(af1), 32'(af));
        chk({tag, " aempty"}, 32'(ae1), 32'(ae));
        chk({tag, " hwm"}, 32'(hwm1), hwm);
    endtask

    // Directed vector: inputs for one cycle and the expected state after the edge.
    typedef struct {
        bit         clr;
        bit         iv;
        logic [7:0] din;
        bit         ordy;
        int         lvl;
        bit         ir;
        bit         ov;
        bit         af;
        bit         ae;
        int         hwm;
        logic [7:0] head;
    } vec_t;

    function automatic vec_t mk(bit clr, bit iv, logic [7:0] din, bit ordy, int lvl, bit ir,
                                bit ov, bit af, bit ae, int hwm, logic [7:0] head);
        vec_t v;
        v.clr = clr; v.iv = iv; v.din = din; v.ordy = ordy; v.lvl = lvl; v.ir = ir;
        v.ov = ov; v.af = af; v.ae = ae; v.hwm = hwm; v.head = head;
        return v;
    endfunction

    vec_t tbl[$];

    // Reference model: a plain queue plus the running maximum.
    logic [7:0] mq[$];
    int         mhwm;
    logic [7:0] got[$];

    task automatic model_check();
        int n;
        n = mq.size();
        chk5("rnd", n, n != 5, n != 0, n >= 4, n <= 1, mhwm);
        if (n != 0) chk("rnd out_data", 32'(dout5), 32'(mq[0]));
    endtask

    initial begin
        int p;
        bit push, pop;
        arstz = 1'b0;
        {clr5, iv5, ordy5, din5} = '0;
        {clr1, iv1, ordy1, din1} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk5("reset5", 0, 1, 0, 0, 1, 0);
        chk1("reset1", 0, 1, 0, 0, 1, 0);
        @(negedge clk);
        arstz = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, reject overflow, drain in order.
        tbl.push_back(mk(0, 1, 8'h11, 0, 1, 1, 1, 0, 1, 1, 8'h11));
        tbl.push_back(mk(0, 1, 8'h12, 0, 2, 1, 1, 0, 0, 2, 8'h11));
        tbl.push_back(mk(0, 1, 8'h13, 0, 3, 1, 1, 0, 0, 3, 8'h11));
        tbl.push_back(mk(0, 1, 8'h14, 0, 4, 1, 1, 1, 0, 4, 8'h11));
        tbl.push_back(mk(0, 1, 8'h15, 0, 5, 0, 1, 1, 0, 5, 8'h11));
        tbl.push_back(mk(0, 1, 8'h66, 0, 5, 0, 1, 1, 0, 5, 8'h11));
        tbl.push_back(mk(0, 0, 8'h00, 1, 4, 1, 1, 1, 0, 5, 8'h12));
        tbl.push_back(mk(0, 0, 8'h00, 1, 3, 1, 1, 0, 0, 5, 8'h13));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2, 1, 1, 0, 0, 5, 8'h14));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 0, 1, 5, 8'h15));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 5, 8'h00));
        // Refill, then simultaneous push/pop at full and at level 2.
        tbl.push_back(mk(0, 1, 8'h21, 0, 1, 1, 1, 0, 1, 5, 8'h21));
        tbl.push_back(mk(0, 1, 8'h22, 0, 2, 1, 1, 0, 0, 5, 8'h21));
        tbl.push_back(mk(0, 1, 8'h23, 0, 3, 1, 1, 0, 0, 5, 8'h21));
        tbl.push_back(mk(0, 1, 8'h24, 0, 4, 1, 1, 1, 0, 5, 8'h21));
        tbl.push_back(mk(0, 1, 8'h25, 0, 5, 0, 1, 1, 0, 5, 8'h21));
        tbl.push_back(mk(0, 1, 8'h99, 1, 4, 1, 1, 1, 0, 5, 8'h22));
        tbl.push_back(mk(0, 0, 8'h00, 1, 3, 1, 1, 0, 0, 5, 8'h23));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2, 1, 1, 0, 0, 5, 8'h24));
        tbl.push_back(mk(0, 1, 8'h26, 1, 2, 1, 1, 0, 0, 5, 8'h25));
        tbl.push_back(mk(0, 1, 8'h27, 1, 2, 1, 1, 0, 0, 5, 8'h26));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 0, 1, 5, 8'h27));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 5, 8'h00));
        // Flush with a concurrent push and pop; the flushed-cycle word is dropped.
        tbl.push_back(mk(0, 1, 8'h31, 0, 1, 1, 1, 0, 1, 5, 8'h31));
        tbl.push_back(mk(0, 1, 8'h32, 0, 2, 1, 1, 0, 0, 5, 8'h31));
        tbl.push_back(mk(0, 1, 8'h33, 0, 3, 1, 1, 0, 0, 5, 8'h31));
        tbl.push_back(mk(1, 1, 8'h34, 1, 0, 1, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'h35, 0, 1, 1, 1, 0, 1, 1, 8'h35));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 1, 8'h00));

        foreach (tbl[i]) begin
            clr5 = tbl[i].clr; iv5 = tbl[i].iv; din5 = tbl[i].din; ordy5 = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk5($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].ir, tbl[i].ov, tbl[i].af,
                 tbl[i].ae, tbl[i].hwm);
            if (tbl[i].ov) chk($sformatf("vec%0d head", i), 32'(dout5), 32'(tbl[i].head));
        end

        // Continuous stream of 12 words across two pointer wraps.
        clr5 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            iv5 = 1'b1; din5 = 8'h40 + 8'(i); ordy5 = 1'b1;
            #1;
            if (ov5) got.push_back(dout5);
            @(posedge clk);
            #1;
            chk("wrap level", 32'(lvl5), 1);
        end
        iv5 = 1'b0; ordy5 = 1'b1;
        #1;
        if (ov5) got.push_back(dout5);
        @(posedge clk);
        #1;
        chk("wrap drained level", 32'(lvl5), 0);
        chk("wrap count", got.size(), 12);
        foreach (got[k]) chk($sformatf("wrap word%0d", k), 32'(got[k]), 32'(8'h40 + k));

        // Random traffic against the queue model, with a mid-run async reset.
        arstz = 1'b0;
        #1;
        arstz = 1'b1;
        mq.delete();
        mhwm = 0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                arstz = 1'b0;
                #1;
                chk5("async reset", 0, 1, 0, 0, 1, 0);
                arstz = 1'b1;
                mq.delete();
                mhwm = 0;
            end
            p = (c < 100) ? 80 : (c < 200) ? 30 : (c < 300) ? 65 : 50;
            iv5   = ($urandom_range(0, 99) < p);
            ordy5 = ($urandom_range(0, 99) < (100 - p));
            clr5  = ($urandom_range(0, 99) < 3);
            din5  = 8'($urandom);
            #1;
            model_check();
            push = iv5 && (mq.size() != 5);
            pop  = ordy5 && (mq.size() != 0);
            @(posedge clk);
            #1;
            if (clr5) begin
                mq.delete();
                mhwm = 0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(din5);
                if (mq.size() > mhwm) mhwm = mq.size();
            end
        end
        {clr5, iv5, ordy5} = '0;

        // DEPTH=1: full blocks push even with a same-cycle pop.
        iv1 = 1'b1; din1 = 8'hA5; ordy1 = 1'b0;
        @(posedge clk);
        #1;
        chk1("d1 push", 1, 0, 1, 1, 0, 1);
        chk("d1 head A5", 32'(dout1), 32'hA5);
        iv1 = 1'b1; din1 = 8'h77; ordy1 = 1'b1;
        @(posedge clk);
        #1;
        chk1("d1 pop while full", 0, 1, 0, 0, 1, 1);
        iv1 = 1'b1; din1 = 8'h5A; ordy1 = 1'b0;
        @(posedge clk);
        #1;
        chk1("d1 push2", 1, 0, 1, 1, 0, 1);
        chk("d1 head 5A", 32'(dout1), 32'h5A);
        iv1 = 1'b0; ordy1 = 1'b1;
        @(posedge clk);
        #1;
        chk1("d1 drain", 0, 1, 0, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
